// File: rtl/ex_dm_pipe_reg.sv
// Execute -> data-memory pipeline register, DEPTH stages deep, with valid tracking,
// flush bubbles and a load-use hazard query. Define EX_DM_PIPE_PERF_EN for stall/bubble counters.
module ex_dm_pipe_reg #(
    parameter int          XLEN     = 32,
    parameter int          RD_W     = 5,
    parameter int          DEPTH    = 1,
    parameter logic [31:0] NOP_INST = 32'h6800_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [31:0]     inst_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            is_ld_in,
    input  logic            is_st_in,
    input  logic            is_wb_in,
    input  logic            is_call_in,
    input  logic [XLEN-1:0] alu_res_in,
    input  logic [XLEN-1:0] op2_in,
    input  logic [XLEN-1:0] b_in,
    input  logic [RD_W-1:0] rd_in,
    output logic            out_valid,
    output logic [31:0]     inst_out,
    output logic [XLEN-1:0] pc_out,
    output logic            is_ld_out,
    output logic            is_st_out,
    output logic            is_wb_out,
    output logic            is_call_out,
    output logic [XLEN-1:0] alu_res_out,
    output logic [XLEN-1:0] op2_out,
    output logic [XLEN-1:0] b_out,
    output logic [RD_W-1:0] rd_out,
    input  logic [RD_W-1:0] src1_q,
    input  logic [RD_W-1:0] src2_q,
    output logic            ld_use_hazard,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     bubble_cnt
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("ex_dm_pipe_reg: DEPTH must be 1..4");
    end

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic            is_ld;
        logic            is_st;
        logic            is_wb;
        logic            is_call;
        logic [XLEN-1:0] alu_res;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] b;
        logic [RD_W-1:0] rd;
    } stage_t;

    localparam int     STAGE_W     = $bits(stage_t);
    // inst is the MSB field, so the bubble is NOP_INST followed by all zeros
    localparam stage_t EMPTY_STAGE = stage_t'({NOP_INST, {(STAGE_W-32){1'b0}}});

    stage_t            in_stage;
    stage_t            stg      [DEPTH];
    logic              vld_pipe [DEPTH];

    always_comb begin
        in_stage         = '0;
        in_stage.inst    = in_valid ? inst_in : NOP_INST;
        in_stage.pc      = pc_in;
        in_stage.is_ld   = is_ld_in   & in_valid;
        in_stage.is_st   = is_st_in   & in_valid;
        in_stage.is_wb   = is_wb_in   & in_valid;
        in_stage.is_call = is_call_in & in_valid;
        in_stage.alu_res = alu_res_in;
        in_stage.op2     = op2_in;
        in_stage.b       = b_in;
        in_stage.rd      = rd_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                stg[k]      <= EMPTY_STAGE;
                vld_pipe[k] <= 1'b0;
            end
        end else if (!stall) begin
            for (int k = DEPTH-1; k > 0; k--) begin
                stg[k]      <= stg[k-1];
                vld_pipe[k] <= vld_pipe[k-1];
            end
            stg[0]      <= in_stage;
            vld_pipe[0] <= in_valid;
        end
    end

    assign out_valid   = vld_pipe[DEPTH-1];
    assign inst_out    = stg[DEPTH-1].inst;
    assign pc_out      = stg[DEPTH-1].pc;
    assign is_ld_out   = stg[DEPTH-1].is_ld;
    assign is_st_out   = stg[DEPTH-1].is_st;
    assign is_wb_out   = stg[DEPTH-1].is_wb;
    assign is_call_out = stg[DEPTH-1].is_call;
    assign alu_res_out = stg[DEPTH-1].alu_res;
    assign op2_out     = stg[DEPTH-1].op2;
    assign b_out       = stg[DEPTH-1].b;
    assign rd_out      = stg[DEPTH-1].rd;

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    always_comb begin
        ld_use_hazard = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld_pipe[k] && stg[k].is_ld && (stg[k].rd != '0) &&
                ((stg[k].rd == src1_q) || (stg[k].rd == src2_q)))
                ld_use_hazard = 1'b1;
        end
    end

`ifdef EX_DM_PIPE_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] bubble_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (stall && !flush && (stall_q != 32'hFFFF_FFFF))
                stall_q <= stall_q + 32'd1;
            if ((flush || (!stall && !in_valid)) && (bubble_q != 32'hFFFF_FFFF))
                bubble_q <= bubble_q + 32'd1;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = 32'd0;
    assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ex_dm_pipe_reg.sv
// Directed bench for ex_dm_pipe_reg: a DEPTH=1 and a DEPTH=2 instance share one stimulus stream.
module tb_ex_dm_pipe_reg;

    localparam logic [31:0] NOP = 32'h6800_0000;
`ifdef EX_DM_PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, in_valid;
    logic [31:0] inst_in, pc_in, alu_res_in, op2_in, b_in;
    logic        is_ld_in, is_st_in, is_wb_in, is_call_in;
    logic [4:0]  rd_in, src1_q, src2_q;

    logic        v1, ld1, st1, wb1, call1, hz1;
    logic [31:0] inst1, pc1, alu1, op21, b1, scnt1, bcnt1;
    logic [4:0]  rd1;
    logic        v2, ld2, st2, wb2, call2, hz2;
    logic [31:0] inst2, pc2, alu2, op22, b2, scnt2, bcnt2;
    logic [4:0]  rd2;

    int errors = 0;
    int checks = 0;
    int exp_stall = 0;
    int exp_bub = 0;

    always #5 clk = ~clk;

    ex_dm_pipe_reg #(.DEPTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .inst_in(inst_in), .pc_in(pc_in), .is_ld_in(is_ld_in), .is_st_in(is_st_in),
        .is_wb_in(is_wb_in), .is_call_in(is_call_in), .alu_res_in(alu_res_in),
        .op2_in(op2_in), .b_in(b_in), .rd_in(rd_in),
        .out_valid(v1), .inst_out(inst1), .pc_out(pc1), .is_ld_out(ld1), .is_st_out(st1),
        .is_wb_out(wb1), .is_call_out(call1), .alu_res_out(alu1), .op2_out(op21),
        .b_out(b1), .rd_out(rd1), .src1_q(src1_q), .src2_q(src2_q),
        .ld_use_hazard(hz1), .stall_cnt(scnt1), .bubble_cnt(bcnt1)
    );

    ex_dm_pipe_reg #(.DEPTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .inst_in(inst_in), .pc_in(pc_in), .is_ld_in(is_ld_in), .is_st_in(is_st_in),
        .is_wb_in(is_wb_in), .is_call_in(is_call_in), .alu_res_in(alu_res_in),
        .op2_in(op2_in), .b_in(b_in), .rd_in(rd_in),
        .out_valid(v2), .inst_out(inst2), .pc_out(pc2), .is_ld_out(ld2), .is_st_out(st2),
        .is_wb_out(wb2), .is_call_out(call2), .alu_res_out(alu2), .op2_out(op22),
        .b_out(b2), .rd_out(rd2), .src1_q(src1_q), .src2_q(src2_q),
        .ld_use_hazard(hz2), .stall_cnt(scnt2), .bubble_cnt(bcnt2)
    );

    // Expected counters follow the control inputs seen at each rising edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (flush)          exp_bub++;
            else if (stall)     exp_stall++;
            else if (!in_valid) exp_bub++;
        end
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; in_valid = 0; inst_in = 0; pc_in = 0;
        is_ld_in = 0; is_st_in = 0; is_wb_in = 0; is_call_in = 0;
        alu_res_in = 0; op2_in = 0; b_in = 0; rd_in = 0; src1_q = 0; src2_q = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        in_valid = 1; inst_in = 32'h1111_0000; pc_in = 32'h10; is_wb_in = 1;
        is_call_in = 1; rd_in = 5'd7; alu_res_in = 32'h55; op2_in = 32'h66; b_in = 32'h77;
        tick();
        checks++; if (v1 !== 1'b1 || pc1 !== 32'h10) begin errors++;
            $display("FAIL pre_reset_d1: valid=%b pc=%h, want 1 / 10", v1, pc1); end
        tick();
        checks++; if (v2 !== 1'b1 || pc2 !== 32'h10) begin errors++;
            $display("FAIL pre_reset_d2: valid=%b pc=%h, want 1 / 10", v2, pc2); end
        #2 rst_n = 0;
        #1;
        checks++; if (inst1 !== NOP || v1 !== 1'b0 || pc1 !== 0 || alu1 !== 0 || op21 !== 0 ||
                      b1 !== 0 || rd1 !== 0 || {ld1, st1, wb1, call1} !== 4'b0) begin errors++;
            $display("FAIL reset_d1: inst=%h v=%b pc=%h alu=%h op2=%h b=%h rd=%0d fl=%b%b%b%b, want NOP/0",
                     inst1, v1, pc1, alu1, op21, b1, rd1, ld1, st1, wb1, call1); end
        checks++; if (inst2 !== NOP || v2 !== 1'b0 || pc2 !== 0 || alu2 !== 0 || rd2 !== 0 ||
                      {ld2, st2, wb2, call2} !== 4'b0) begin errors++;
            $display("FAIL reset_d2: inst=%h v=%b pc=%h alu=%h rd=%0d, want NOP/0",
                     inst2, v2, pc2, alu2, rd2); end
        checks++; if (scnt1 !== 0 || bcnt1 !== 0 || hz1 !== 1'b0) begin errors++;
            $display("FAIL reset_cnt: stall=%0d bubble=%0d hz=%b, want 0", scnt1, bcnt1, hz1); end
        exp_stall = 0; exp_bub = 0;
        tick();
        clear_inputs();
        rst_n = 1;
    endtask

    task automatic test_advance();
        in_valid = 1; inst_in = 32'hABCD_0001; pc_in = 32'h40; alu_res_in = 32'h1234;
        op2_in = 32'h11; b_in = 32'h22; is_wb_in = 1; rd_in = 5'd3;
        tick();
        checks++; if (v2 !== 1'b0 || v1 !== 1'b1 || pc1 !== 32'h40) begin errors++;
            $display("FAIL adv_lat1: d2 valid=%b d1 valid=%b d1 pc=%h, want 0 1 40", v2, v1, pc1); end
        inst_in = 32'hABCD_0002; pc_in = 32'h44; alu_res_in = 32'h2222; rd_in = 5'd4;
        tick();
        checks++; if (v2 !== 1'b1 || pc2 !== 32'h40 || alu2 !== 32'h1234 || wb2 !== 1'b1 ||
                      rd2 !== 5'd3 || inst2 !== 32'hABCD_0001 || op22 !== 32'h11 || b2 !== 32'h22) begin
            errors++;
            $display("FAIL adv_d2: v=%b pc=%h alu=%h wb=%b rd=%0d inst=%h, want 1 40 1234 1 3 abcd0001",
                     v2, pc2, alu2, wb2, rd2, inst2); end
        checks++; if (pc1 !== 32'h44 || alu1 !== 32'h2222) begin errors++;
            $display("FAIL adv_d1: pc=%h alu=%h, want 44 2222", pc1, alu1); end
    endtask

    task automatic test_stall();
        stall = 1; pc_in = 32'h48; alu_res_in = 32'h3333; rd_in = 5'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (v2 !== 1'b1 || pc2 !== 32'h40 || rd2 !== 5'd3 || pc1 !== 32'h44) begin
                errors++;
                $display("FAIL stall_hold[%0d]: d2 v=%b pc=%h rd=%0d d1 pc=%h, want 1 40 3 / 44",
                         i, v2, pc2, rd2, pc1); end
        end
        checks++; if (scnt2 !== (PERF ? 32'd3 : 32'd0) || scnt1 !== scnt2) begin errors++;
            $display("FAIL stall_cnt: got %0d/%0d, want %0d", scnt1, scnt2, PERF ? 3 : 0); end
    endtask

    task automatic test_flush();
        stall = 1; flush = 1;
        tick();
        checks++; if (v2 !== 1'b0 || wb2 !== 1'b0 || inst2 !== NOP || pc2 !== 0 || rd2 !== 0) begin
            errors++;
            $display("FAIL flush_d2: v=%b wb=%b inst=%h pc=%h rd=%0d, want 0 0 NOP 0 0",
                     v2, wb2, inst2, pc2, rd2); end
        checks++; if (v1 !== 1'b0 || inst1 !== NOP) begin errors++;
            $display("FAIL flush_d1: v=%b inst=%h, want 0 NOP", v1, inst1); end
        checks++; if (bcnt2 !== (PERF ? 32'd1 : 32'd0) || scnt2 !== (PERF ? 32'd3 : 32'd0)) begin
            errors++;
            $display("FAIL flush_cnt: bubble=%0d stall=%0d, want %0d %0d",
                     bcnt2, scnt2, PERF ? 1 : 0, PERF ? 3 : 0); end
        stall = 0; flush = 0; in_valid = 0;
        tick();
        checks++; if (v2 !== 1'b0 || inst2 !== NOP) begin errors++;
            $display("FAIL flush_stage0: v=%b inst=%h, want 0 NOP", v2, inst2); end
    endtask

    task automatic test_hazard();
        clear_inputs();
        in_valid = 1; is_ld_in = 1; is_wb_in = 1; rd_in = 5'd5; inst_in = 32'h0C00_0005;
        tick();
        src1_q = 5'd5; src2_q = 5'd0; #1;
        checks++; if (hz2 !== 1'b1 || hz1 !== 1'b1) begin errors++;
            $display("FAIL hz_src1: got %b/%b, want 1/1", hz1, hz2); end
        src1_q = 5'd6; #1;
        checks++; if (hz2 !== 1'b0 || hz1 !== 1'b0) begin errors++;
            $display("FAIL hz_nomatch: got %b/%b, want 0/0", hz1, hz2); end
        src2_q = 5'd5; #1;
        checks++; if (hz2 !== 1'b1) begin errors++;
            $display("FAIL hz_src2: got %b, want 1", hz2); end
        // non-load pushes the load into the DEPTH=2 output stage
        is_ld_in = 0; rd_in = 5'd8;
        tick();
        checks++; if (hz2 !== 1'b1 || hz1 !== 1'b0) begin errors++;
            $display("FAIL hz_outstage: got d1=%b d2=%b, want 0 1", hz1, hz2); end
        flush = 1;
        tick();
        flush = 0; is_ld_in = 1; rd_in = 5'd0; src1_q = 5'd0; src2_q = 5'd0;
        tick();
        checks++; if (hz2 !== 1'b0 || hz1 !== 1'b0 || ld1 !== 1'b1) begin errors++;
            $display("FAIL hz_r0: hz=%b/%b ld=%b, want 0/0 1", hz1, hz2, ld1); end
        in_valid = 0; rd_in = 5'd5; src1_q = 5'd5;
        tick(); tick();
        checks++; if (hz2 !== 1'b0 || hz1 !== 1'b0) begin errors++;
            $display("FAIL hz_invalid_ld: got %b/%b, want 0/0", hz1, hz2); end
    endtask

    task automatic test_invalid();
        clear_inputs();
        in_valid = 0; is_st_in = 1; inst_in = 32'h1234_5678; pc_in = 32'h80;
        rd_in = 5'd9; alu_res_in = 32'h99;
        tick();
        checks++; if (st1 !== 1'b0 || v1 !== 1'b0 || inst1 !== NOP || pc1 !== 32'h80 ||
                      rd1 !== 5'd9 || alu1 !== 32'h99) begin errors++;
            $display("FAIL inv_d1: st=%b v=%b inst=%h pc=%h rd=%0d alu=%h, want 0 0 NOP 80 9 99",
                     st1, v1, inst1, pc1, rd1, alu1); end
        tick();
        checks++; if (st2 !== 1'b0 || v2 !== 1'b0 || inst2 !== NOP || pc2 !== 32'h80) begin errors++;
            $display("FAIL inv_d2: st=%b v=%b inst=%h pc=%h, want 0 0 NOP 80", st2, v2, inst2, pc2); end
        checks++; if (bcnt2 !== (PERF ? exp_bub : 0) || scnt2 !== (PERF ? exp_stall : 0)) begin
            errors++;
            $display("FAIL final_cnt: bubble=%0d stall=%0d, want %0d %0d",
                     bcnt2, scnt2, PERF ? exp_bub : 0, PERF ? exp_stall : 0); end
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        test_reset();
        test_advance();
        test_stall();
        test_flush();
        test_hazard();
        test_invalid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
